// File: rtl/div_unit_pkg.sv
// Shared widths, op/state encodings and small helpers for the RV32M divide unit.
package div_unit_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int DIV_OP_W   = 2;

  localparam logic [DIV_OP_W-1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [DIV_OP_W-1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [DIV_OP_W-1:0] DIV_OP_REM  = 2'b10;
  localparam logic [DIV_OP_W-1:0] DIV_OP_REMU = 2'b11;

  localparam logic [RegBus-1:0]     ZeroWord = '0;
  localparam logic [RegAddrBus-1:0] ZeroReg  = '0;
  localparam logic [RegBus-1:0]     MinInt   = {1'b1, {(RegBus-1){1'b0}}};

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [RegBus-1:0] abs_word(input logic [RegBus-1:0] v);
    return v[RegBus-1] ? (ZeroWord - v) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request / write-back bundle between the EX stage and the divide unit.
interface div_unit_if;

  logic                                   start;
  logic [div_unit_pkg::DIV_OP_W-1:0]      op;
  logic [div_unit_pkg::RegBus-1:0]        dividend;
  logic [div_unit_pkg::RegBus-1:0]        divisor;
  logic [div_unit_pkg::RegAddrBus-1:0]    rd_addr_i;
  logic                                   flush;
  logic                                   busy;
  logic [div_unit_pkg::RegAddrBus-1:0]    rd_waddr;
  logic [div_unit_pkg::RegBus-1:0]        rd_wdata;
  logic                                   wen;

  modport master (
    output start, op, dividend, divisor, rd_addr_i, flush,
    input  busy, rd_waddr, rd_wdata, wen
  );

  modport slave (
    input  start, op, dividend, divisor, rd_addr_i, flush,
    output busy, rd_waddr, rd_wdata, wen
  );

endinterface

// File: rtl/div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring iteration with
// registered one-cycle write-back; special cases complete without iterating.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  div_unit_if.slave  bus
);

  div_state_e             state_reg, state_next;
  logic [DIV_OP_W-1:0]    op_reg, op_next;
  logic [RegAddrBus-1:0]  rd_reg, rd_next;
  logic                   neg_q_reg, neg_q_next;
  logic                   neg_r_reg, neg_r_next;
  logic [RegBus-1:0]      rem_reg, rem_next;
  logic [RegBus-1:0]      quo_reg, quo_next;
  logic [RegBus-1:0]      dsor_reg, dsor_next;
  logic [5:0]             cnt_reg, cnt_next;
  logic                   wen_reg, wen_next;
  logic [RegAddrBus-1:0]  waddr_reg, waddr_next;
  logic [RegBus-1:0]      wdata_reg, wdata_next;

  logic [RegBus+1:0]      trial;
  logic [RegBus-1:0]      iter_rem, iter_quo, fix_result, special_result;
  logic                   signed_op, div_by_zero, overflow;

  // Shift {rem, quo} left by one and trial-subtract from the upper 33 bits.
  assign trial    = {1'b0, rem_reg, quo_reg[RegBus-1]} - {2'b00, dsor_reg};
  assign iter_rem = trial[RegBus+1] ? {rem_reg[RegBus-2:0], quo_reg[RegBus-1]}
                                    : trial[RegBus-1:0];
  assign iter_quo = {quo_reg[RegBus-2:0], ~trial[RegBus+1]};

  always_comb begin
    fix_result = iter_rem;
    case (op_reg)
      DIV_OP_DIV:  fix_result = neg_q_reg ? (ZeroWord - iter_quo) : iter_quo;
      DIV_OP_DIVU: fix_result = iter_quo;
      DIV_OP_REM:  fix_result = neg_r_reg ? (ZeroWord - iter_rem) : iter_rem;
      default:     fix_result = iter_rem;
    endcase
  end

  assign signed_op   = ~bus.op[0];
  assign div_by_zero = (bus.divisor == ZeroWord);
  assign overflow    = signed_op && (bus.dividend == MinInt) && (bus.divisor == '1);

  always_comb begin
    special_result = bus.op[1] ? ZeroWord : MinInt;
    if (div_by_zero) begin
      special_result = bus.op[1] ? bus.dividend : '1;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    rd_next    = rd_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    rem_next   = rem_reg;
    quo_next   = quo_reg;
    dsor_next  = dsor_reg;
    cnt_next   = cnt_reg;
    wen_next   = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;

    case (state_reg)
      DIV_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_next    = bus.op;
          rd_next    = bus.rd_addr_i;
          neg_q_next = signed_op & (bus.dividend[RegBus-1] ^ bus.divisor[RegBus-1]);
          neg_r_next = signed_op & bus.dividend[RegBus-1];
          if (div_by_zero || overflow) begin
            state_next = DIV_DONE;
            if (bus.rd_addr_i != ZeroReg) begin
              wen_next   = 1'b1;
              waddr_next = bus.rd_addr_i;
              wdata_next = special_result;
            end
          end else begin
            state_next = DIV_CALC;
            rem_next   = ZeroWord;
            quo_next   = signed_op ? abs_word(bus.dividend) : bus.dividend;
            dsor_next  = signed_op ? abs_word(bus.divisor)  : bus.divisor;
            cnt_next   = 6'd0;
          end
        end
      end
      DIV_CALC: begin
        if (bus.flush) begin
          state_next = DIV_IDLE;
        end else begin
          rem_next = iter_rem;
          quo_next = iter_quo;
          cnt_next = cnt_reg + 6'd1;
          // Final iteration: fix-up and write-back land on the same edge.
          if (cnt_reg == 6'd31) begin
            state_next = DIV_DONE;
            if (rd_reg != ZeroReg) begin
              wen_next   = 1'b1;
              waddr_next = rd_reg;
              wdata_next = fix_result;
            end
          end
        end
      end
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= DIV_IDLE;
      op_reg    <= DIV_OP_DIV;
      rd_reg    <= ZeroReg;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      rem_reg   <= ZeroWord;
      quo_reg   <= ZeroWord;
      dsor_reg  <= ZeroWord;
      cnt_reg   <= 6'd0;
      wen_reg   <= 1'b0;
      waddr_reg <= ZeroReg;
      wdata_reg <= ZeroWord;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      rd_reg    <= rd_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      rem_reg   <= rem_next;
      quo_reg   <= quo_next;
      dsor_reg  <= dsor_next;
      cnt_reg   <= cnt_next;
      wen_reg   <= wen_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
    end
  end

  assign bus.busy     = (state_reg != DIV_IDLE);
  assign bus.wen      = wen_reg;
  assign bus.rd_waddr = waddr_reg;
  assign bus.rd_wdata = wdata_reg;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed timing cases plus random operations
// checked against plain-arithmetic RV32M division semantics.
module tb_div_unit;

  logic clk;
  logic rstn;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  div_unit_if bus();

  div_unit dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_model(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic is_rem;
    logic is_uns;
    is_rem = op[1];
    is_uns = op[0];
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (!is_uns && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return is_rem ? 32'd0 : 32'h8000_0000;
    if (is_uns) return is_rem ? (a % b) : (a / b);
    return is_rem ? $unsigned($signed(a) % $signed(b))
                  : $unsigned($signed(a) / $signed(b));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && bus.wen === 1'b1) begin
        $display("wb  cyc=%0d rd=%0d data=%h", cyc, bus.rd_waddr, bus.rd_wdata);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_wen: got wen=1 rd=%0d at cycle %0d required no write-back",
                   bus.rd_waddr, cyc);
        end else begin
          e = exp_q.pop_front();
          check("wb_cycle", 32'(cyc), 32'(e.cyc));
          check("wb_addr", {27'd0, bus.rd_waddr}, {27'd0, e.rd});
          check("wb_data", bus.rd_wdata, e.data);
        end
      end
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that sampled start.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit expect_wb,
                       input logic [31:0] req, output int t);
    int guard;
    int lat;
    guard = 0;
    while (bus.busy !== 1'b0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: got busy=1 for 100 cycles required idle");
    end
    bus.start     = 1'b1;
    bus.op        = op;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.rd_addr_i = rd;
    t = cyc;
    lat = (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
    if (expect_wb && rd != 5'd0) exp_q.push_back('{rd, req, t + lat});
    $display("req cyc=%0d op=%0d a=%h b=%h rd=%0d", t, op, a, b, rd);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t;
    int t2;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_rd;
    int          kind;

    n_cmp = 0;
    n_bad = 0;
    rstn = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op = 2'd0;
    bus.dividend = 32'd0;
    bus.divisor = 32'd0;
    bus.rd_addr_i = 5'd0;

    fork
      monitor();
      begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_wen", {31'd0, bus.wen}, 32'd0);
    check("rst_waddr", {27'd0, bus.rd_waddr}, 32'd0);
    check("rst_wdata", bus.rd_wdata, 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // DIVU 100/7 with full timing checks
    issue(2'd1, 32'd100, 32'd7, 5'd5, 1'b1, 32'd14, t);
    check("divu_busy_t1", {31'd0, bus.busy}, 32'd1);
    wait_until(t + 32);
    check("divu_wen_t32", {31'd0, bus.wen}, 32'd0);
    wait_until(t + 33);
    check("divu_busy_t33", {31'd0, bus.busy}, 32'd1);
    check("divu_wen_t33", {31'd0, bus.wen}, 32'd1);
    wait_until(t + 34);
    check("divu_busy_t34", {31'd0, bus.busy}, 32'd0);
    check("divu_wen_t34", {31'd0, bus.wen}, 32'd0);
    check("divu_hold_data", bus.rd_wdata, 32'd14);

    issue(2'd3, 32'd100, 32'd7, 5'd6, 1'b1, 32'd2, t);
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1, 32'hFFFF_FFFD, t);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1, 32'hFFFF_FFFF, t);

    // divide by zero resolves at accept
    issue(2'd1, 32'h1234, 32'd0, 5'd8, 1'b1, 32'hFFFF_FFFF, t);
    check("dz_busy_t1", {31'd0, bus.busy}, 32'd1);
    check("dz_wen_t1", {31'd0, bus.wen}, 32'd1);
    wait_until(t + 2);
    check("dz_busy_t2", {31'd0, bus.busy}, 32'd0);
    issue(2'd3, 32'h1234, 32'd0, 5'd8, 1'b1, 32'h1234, t);
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1, 32'h8000_0000, t);
    check("ovf_busy_t1", {31'd0, bus.busy}, 32'd1);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1, 32'd0, t);

    // flush mid-calculation, then restart in the first idle cycle
    issue(2'd1, 32'hFFFF_FFFF, 32'd3, 5'd9, 1'b0, 32'd0, t);
    wait_until(t + 10);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    issue(2'd1, 32'd1000, 32'd10, 5'd10, 1'b1, 32'd100, t2);
    check("restart_cycle", 32'(t2), 32'(t + 11));
    wait_until(t2 + 34);

    // flush beats start in the same idle cycle
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op = 2'd1;
    bus.dividend = 32'd5;
    bus.divisor = 32'd0;
    bus.rd_addr_i = 5'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("flush_drops_start", {31'd0, bus.busy}, 32'd0);

    // rd=0: runs full length, no write-back
    issue(2'd1, 32'd8, 32'd2, 5'd0, 1'b1, 32'd4, t);
    check("rd0_busy_t1", {31'd0, bus.busy}, 32'd1);
    wait_until(t + 33);
    check("rd0_busy_t33", {31'd0, bus.busy}, 32'd1);
    check("rd0_wen_t33", {31'd0, bus.wen}, 32'd0);
    wait_until(t + 34);
    check("rd0_busy_t34", {31'd0, bus.busy}, 32'd0);

    // reset mid-operation clears outputs
    issue(2'd1, 32'd77, 32'd5, 5'd3, 1'b0, 32'd0, t);
    wait_until(t + 15);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check("mrst_busy", {31'd0, bus.busy}, 32'd0);
    check("mrst_wen", {31'd0, bus.wen}, 32'd0);
    check("mrst_waddr", {27'd0, bus.rd_waddr}, 32'd0);
    check("mrst_wdata", bus.rd_wdata, 32'd0);

    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_rd = 5'($urandom_range(0, 31));
      kind = int'($urandom_range(0, 9));
      r_a  = $urandom;
      r_b  = $urandom;
      if (kind == 0) r_b = 32'd0;
      else if (kind == 1) begin
        r_a = 32'h8000_0000;
        r_b = 32'hFFFF_FFFF;
      end else if (kind == 2) begin
        r_a = 32'($urandom_range(0, 1000));
        r_b = 32'($urandom_range(1, 20));
      end else if (kind == 3) r_b = 32'($urandom_range(1, 300)) ^ {32{r_b[31]}};
      issue(r_op, r_a, r_b, r_rd, 1'b1, ref_model(r_op, r_a, r_b), t);
    end

    wait_until(cyc + 40);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle RV32M divide/remainder unit inside the EX stage. It accepts DIV/DIVU/REM/REMU operands taken from the register file read ports, computes the result with a radix-2 restoring iteration, and drives a one-cycle write-back onto the register file write port (rd_waddr/rd_wdata/wen). While an operation is in flight, `busy` stalls the pipeline.

## Interface
- No parameters. Widths come from the shared defines: `RegBus` = 32 bits, `RegAddrBus` = 5 bits.
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  in  32  rs1 value.
- divisor  in  32  rs2 value.
- rd_addr_i  in  5  destination register.
- flush  in  1  abort the in-flight operation (branch/trap).
- busy  out  1  operation in flight; stall request to the pipeline.
- rd_waddr  out  5  write-back address to the register file.
- rd_wdata  out  32  write-back data.
- wen  out  1  write-back strobe; one-cycle pulse.

## Operation
- Reset values: busy=0, wen=0, rd_waddr=0, rd_wdata=`ZeroWord`; FSM in IDLE.
- States and transitions:
  - IDLE → CALC on `start` for the normal case.
  - IDLE → DONE on `start` for a special case.
  - CALC → DONE after 32 iterations.
  - DONE → IDLE unconditionally.
- On accept, latch op, rd_addr_i, and the operand signs. For DIV/REM, latch absolute values of both operands; for DIVU/REMU, latch the operands as-is.
- Special cases, resolved at accept (no CALC):
  - divisor=0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = dividend.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: DIV result 0x80000000; REM result 0.
- CALC, one iteration per cycle:
  - 64-bit shift of {remainder, quotient}.
  - Trial subtract of the divisor from the upper 33 bits.
  - If the result is non-negative, keep it and set the quotient LSB; otherwise restore.
  - A 6-bit counter counts 0..31.
- DONE sign fix-up:
  - DIV: negate the quotient when the operand signs differ.
  - REM: the remainder takes the sign of the dividend.
- Output registers load the result in the same cycle `wen` goes high.
- wen stays 0 if rd_addr_i=0. The operation still runs and busy still asserts.
- rd_waddr and rd_wdata hold their last value after wen drops.
- `start` while busy is ignored.
- flush in CALC or DONE: next state IDLE, busy=0, no wen.
- flush has priority over start in the same cycle; that start is dropped.
- rstn low in any state: return to reset values on the next edge, no wen.

## Timing
- `start` sampled at edge T, normal case:
  - busy=1 from T+1 through T+33.
  - wen=1 for exactly cycle T+33.
  - busy=0 at T+34, when a new start is accepted.
- Special case: busy=1 and wen=1 at T+1 only; busy=0 at T+2.
- Outputs are registered; there is no combinational path from any input to any output.
- flush sampled at edge F: busy=0 at F+1, wen never asserts for the aborted operation.

## Structure
- Shared defines file:
  - op encodings DIV_OP_DIV/DIVU/REM/REMU.
  - DIV_OP_W=2.
  - `RegBus`, `RegAddrBus`, `ZeroWord`, `ZeroReg`.
  - state encodings DIV_IDLE/CALC/DONE.
- Single module with no sub-module; the iteration datapath is small enough to stay inline.

## Test plan
- DIVU 100/7 with rd=5, start at T: wen only at T+33 with rd_waddr=5, rd_wdata=14. REMU with the same operands gives 2.
- DIV 0xFFFFFFF9 (-7) / 2 gives 0xFFFFFFFD (-3). REM with the same operands gives 0xFFFFFFFF (-1).
- DIVU 0x1234/0 gives 0xFFFFFFFF with wen at T+1. REMU 0x1234/0 gives 0x1234 at T+1.
- DIV 0x80000000/0xFFFFFFFF gives 0x80000000 at T+1. REM with the same operands gives 0.
- flush at T+10: busy=0 at T+11 and wen never asserts. A start at T+11 is accepted, and its wen lands at T+44.
- rd=0 DIVU 8/2: busy asserts T+1..T+33 but wen stays 0. rstn low at T+15: all outputs return to reset values at T+16.
